// File: rtl/arm_mc_pkg.sv
// rtl/arm_mc_pkg.sv - shared state, opcode, DP command and ALU code constants
package arm_mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXECR   = 4'd6;
  localparam state_t S_EXECI   = 4'd7;
  localparam state_t S_ALUWB   = 4'd8;
  localparam state_t S_BRANCH  = 4'd9;
  localparam state_t S_UNKNOWN = 4'd10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_EOR  = 3'b100;
  localparam logic [2:0] ALU_MOVB = 3'b101;

endpackage

// File: rtl/arm_mc_aludec.sv
// rtl/arm_mc_aludec.sv - combinational DP command decoder producing ALU control and flag writes
module arm_mc_aludec
  import arm_mc_pkg::*;
#(
  parameter  int EXT_OPS    = 1,
  localparam int ALU_CTRL_W = (EXT_OPS != 0) ? 3 : 2
) (
  input  logic                  alu_op,
  input  logic                  is_dp,
  input  logic [4:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            flag_w,
  output logic                  no_write,
  output logic                  supported
);

  logic [3:0] cmd;
  logic       s_bit;
  logic [2:0] code;
  logic       arith;
  logic       nw;
  logic       ext_en;

  always_comb begin
    cmd       = funct[4:1];
    s_bit     = funct[0];
    ext_en    = (EXT_OPS != 0);
    code      = ALU_ADD;
    supported = 1'b1;
    arith     = 1'b0;
    nw        = 1'b0;
    case (cmd)
      CMD_ADD: begin code = ALU_ADD; arith = 1'b1; end
      CMD_SUB: begin code = ALU_SUB; arith = 1'b1; end
      CMD_AND: code = ALU_AND;
      CMD_ORR: code = ALU_ORR;
      CMD_CMP: begin code = ALU_SUB; arith = 1'b1; nw = 1'b1; end
      CMD_EOR: begin code = ALU_EOR; supported = ext_en; end
      CMD_TST: begin code = ALU_AND; nw = ext_en; supported = ext_en; end
      CMD_MOV: begin code = ALU_MOVB; supported = ext_en; end
      default: supported = 1'b0;
    endcase
    no_write    = is_dp & nw;
    // Narrow ALUs only see the low code bits of the base set.
    alu_control = alu_op ? code[ALU_CTRL_W-1:0] : '0;
    flag_w      = alu_op ? {s_bit, s_bit & arith} : 2'b00;
  end

endmodule

// File: rtl/arm_mc_controller.sv
// rtl/arm_mc_controller.sv - multicycle ARM control unit: Moore main FSM, PC logic, retire counter
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter  int EXT_OPS    = 1,
  parameter  int MEM_WAIT   = 1,
  parameter  int CNT_W      = 32,
  localparam int ALU_CTRL_W = (EXT_OPS != 0) ? 3 : 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic                  MemReady,
  output logic                  IRWrite,
  output logic                  NextPC,
  output logic                  RegW,
  output logic                  MemW,
  output logic                  Branch,
  output logic                  PCS,
  output logic                  AdrSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            FlagW,
  output logic                  NoWrite,
  output logic                  Illegal,
  output logic [CNT_W-1:0]      Retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       mem_ready;
  logic       is_dp;
  logic       dp_ok;
  logic       alu_op;
  logic       no_write;
  logic [1:0] flag_w_raw;
  logic       ir_write, next_pc, reg_w, mem_w, branch, illegal;

  assign mem_ready = (MEM_WAIT != 0) ? MemReady : 1'b1;
  assign is_dp     = (Op == OP_DP);

  arm_mc_aludec #(.EXT_OPS(EXT_OPS)) u_aludec (
    .alu_op      (alu_op),
    .is_dp       (is_dp),
    .funct       (Funct[4:0]),
    .alu_control (ALUControl),
    .flag_w      (flag_w_raw),
    .no_write    (no_write),
    .supported   (dp_ok)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP: begin
            if (!dp_ok)        state_d = S_UNKNOWN;
            else if (Funct[5]) state_d = S_EXECI;
            else               state_d = S_EXECR;
          end
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = no_write ? S_FETCH : S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_write  = 1'b0;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        next_pc   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      S_UNKNOWN: illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      OP_MEM: begin
        ImmSrc = 2'b01;
        RegSrc = Funct[0] ? 2'b00 : 2'b10;
      end
      OP_BR: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase
  end

  // Write enables are held off while reset is asserted so an aborted access never commits.
  assign IRWrite = ir_write & reset_n;
  assign NextPC  = next_pc & reset_n;
  assign RegW    = reg_w & reset_n;
  assign MemW    = mem_w & reset_n;
  assign Branch  = branch & reset_n;
  assign Illegal = illegal & reset_n;
  assign FlagW   = flag_w_raw & {2{reset_n}};
  assign NoWrite = no_write;
  assign PCS     = ((Rd == 4'd15) & RegW) | Branch;
  assign Retired = retired_q;

  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_UNKNOWN)
      retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb/tb_arm_mc_controller.sv - directed bench for arm_mc_controller (EXT_OPS=1 and EXT_OPS=0 instances)
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [5:0]  Funct = 6'b000000;
  logic [3:0]  Rd = 4'd0;
  logic        MemReady = 1'b0;

  logic        IRWrite, NextPC, RegW, MemW, Branch, PCS, AdrSrc, ALUSrcA, NoWrite, Illegal;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
  logic [2:0]  ALUControl;
  logic [31:0] Retired;

  logic        IRWrite_0, NextPC_0, RegW_0, MemW_0, Branch_0, PCS_0, AdrSrc_0, ALUSrcA_0, NoWrite_0, Illegal_0;
  logic [1:0]  ALUSrcB_0, ResultSrc_0, ImmSrc_0, RegSrc_0, FlagW_0;
  logic [1:0]  ALUControl_0;
  logic [31:0] Retired_0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  arm_mc_controller #(.EXT_OPS(1), .MEM_WAIT(1), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch), .PCS(PCS),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .NoWrite(NoWrite), .Illegal(Illegal), .Retired(Retired)
  );

  arm_mc_controller #(.EXT_OPS(0), .MEM_WAIT(1), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .IRWrite(IRWrite_0), .NextPC(NextPC_0), .RegW(RegW_0), .MemW(MemW_0), .Branch(Branch_0), .PCS(PCS_0),
    .AdrSrc(AdrSrc_0), .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0), .ResultSrc(ResultSrc_0),
    .ImmSrc(ImmSrc_0), .RegSrc(RegSrc_0), .ALUControl(ALUControl_0), .FlagW(FlagW_0),
    .NoWrite(NoWrite_0), .Illegal(Illegal_0), .Retired(Retired_0)
  );

  // {IRWrite,NextPC,RegW,MemW,Branch,PCS,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,NoWrite,Illegal}
  logic [18:0] sig;
  assign sig = {IRWrite, NextPC, RegW, MemW, Branch, PCS, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl, FlagW, NoWrite, Illegal};

  localparam logic [18:0] FETCH_RDY  = 19'b11_0000_0_1_10_10_000_00_0_0;
  localparam logic [18:0] FETCH_WAIT = 19'b00_0000_0_1_10_10_000_00_0_0;
  localparam logic [18:0] DECODE_S   = 19'b00_0000_0_1_10_10_000_00_0_0;
  localparam logic [18:0] MEMADR_S   = 19'b00_0000_0_0_01_00_000_00_0_0;
  localparam logic [18:0] MEMRD_S    = 19'b00_0000_1_0_00_00_000_00_0_0;
  localparam logic [18:0] MEMWB_S    = 19'b00_1000_0_0_00_01_000_00_0_0;
  localparam logic [18:0] MEMWR_S    = 19'b00_0100_1_0_00_00_000_00_0_0;
  localparam logic [18:0] EXECI_ADD  = 19'b00_0000_0_0_01_00_000_00_0_0;
  localparam logic [18:0] EXECR_CMPS = 19'b00_0000_0_0_00_00_001_11_1_0;
  localparam logic [18:0] EXECR_EOR  = 19'b00_0000_0_0_00_00_100_00_0_0;
  localparam logic [18:0] ALUWB_S    = 19'b00_1000_0_0_00_00_000_00_0_0;
  localparam logic [18:0] ALUWB_PCS  = 19'b00_1001_0_0_00_00_000_00_0_0;
  localparam logic [18:0] BRANCH_S   = 19'b00_0011_0_0_01_10_000_00_0_0;
  localparam logic [18:0] UNKNOWN_S  = 19'b00_0000_0_0_00_00_000_00_0_1;
  localparam logic [18:0] NW         = 19'b00_0000_0_0_00_00_000_00_1_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [18:0] exp);
    #2;
    chk(tag, {13'd0, sig}, {13'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // ADD r1,r2,#5 staged while still in reset
    Op = 2'b00; Funct = 6'b101000; Rd = 4'd1; MemReady = 1'b1;
    #2;
    chk("rst.retired", Retired, 32'd0);
    chk("rst.sig", {13'd0, sig}, {13'd0, FETCH_WAIT});
    reset_n = 1'b1;

    step("add.fetch", FETCH_RDY);
    chk("add.imm_reg", {28'd0, ImmSrc, RegSrc}, 32'h0);
    step("add.decode", DECODE_S);
    step("add.execi", EXECI_ADD);
    step("add.aluwb", ALUWB_S);
    chk("add.retired", Retired, 32'd1);

    Op = 2'b01; Funct = 6'b011001; Rd = 4'd3; MemReady = 1'b0;
    step("ldr.fetch_wait", FETCH_WAIT);
    chk("ldr.retired_stall", Retired, 32'd1);
    MemReady = 1'b1;
    step("ldr.fetch", FETCH_RDY);
    chk("ldr.imm_reg", {28'd0, ImmSrc, RegSrc}, 32'h4);
    step("ldr.decode", DECODE_S);
    step("ldr.memadr", MEMADR_S);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) step("ldr.memrd_wait", MEMRD_S);
    MemReady = 1'b1;
    step("ldr.memrd", MEMRD_S);
    step("ldr.memwb", MEMWB_S);
    chk("ldr.retired", Retired, 32'd2);

    Op = 2'b01; Funct = 6'b011000; Rd = 4'd4; MemReady = 1'b1;
    step("str.fetch", FETCH_RDY);
    chk("str.imm_reg", {28'd0, ImmSrc, RegSrc}, 32'h6);
    step("str.decode", DECODE_S);
    step("str.memadr", MEMADR_S);
    MemReady = 1'b0;
    step("str.memwr0", MEMWR_S);
    step("str.memwr1", MEMWR_S);
    MemReady = 1'b1;
    step("str.memwr2", MEMWR_S);
    chk("str.retired", Retired, 32'd3);

    Op = 2'b00; Funct = 6'b010101; Rd = 4'd0; MemReady = 1'b1;
    step("cmp.fetch", FETCH_RDY | NW);
    step("cmp.decode", DECODE_S | NW);
    #2;
    chk("cmp.execr", {13'd0, sig}, {13'd0, EXECR_CMPS});
    chk("cmp.alu_narrow", {30'd0, ALUControl_0}, 32'h1);
    @(posedge clk);
    #1;
    chk("cmp.retired", Retired, 32'd4);

    Op = 2'b00; Funct = 6'b000010; Rd = 4'd5; MemReady = 1'b1;
    step("eor.fetch", FETCH_RDY);
    step("eor.decode", DECODE_S);
    #2;
    chk("eor.execr", {13'd0, sig}, {13'd0, EXECR_EOR});
    chk("eor0.illegal", {31'd0, Illegal_0}, 32'd1);
    @(posedge clk);
    #1;
    #2;
    chk("eor.aluwb", {13'd0, sig}, {13'd0, ALUWB_S});
    chk("eor0.illegal_end", {31'd0, Illegal_0}, 32'd0);
    chk("eor0.retired", Retired_0, 32'd4);
    @(posedge clk);
    #1;
    chk("eor.retired", Retired, 32'd5);

    Op = 2'b11; Funct = 6'b000000; Rd = 4'd0; MemReady = 1'b1;
    step("und.fetch", FETCH_RDY);
    chk("und.imm_reg", {28'd0, ImmSrc, RegSrc}, 32'h0);
    step("und.decode", DECODE_S);
    step("und.unknown", UNKNOWN_S);
    chk("und.retired", Retired, 32'd5);

    Op = 2'b10; Funct = 6'b000000; Rd = 4'd0; MemReady = 1'b1;
    step("b.fetch", FETCH_RDY);
    chk("b.imm_reg", {28'd0, ImmSrc, RegSrc}, 32'h9);
    step("b.decode", DECODE_S);
    step("b.branch", BRANCH_S);
    chk("b.retired", Retired, 32'd6);

    Op = 2'b01; Funct = 6'b011000; Rd = 4'd4; MemReady = 1'b1;
    step("rstwr.fetch", FETCH_RDY);
    step("rstwr.decode", DECODE_S);
    step("rstwr.memadr", MEMADR_S);
    MemReady = 1'b0;
    #2;
    chk("rstwr.memw", {31'd0, MemW}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstwr.memw_forced", {31'd0, MemW}, 32'd0);
    chk("rstwr.retired", Retired, 32'd0);
    chk("rstwr.retired0", Retired_0, 32'd0);
    MemReady = 1'b1;
    #1;
    chk("rstwr.sig", {13'd0, sig}, {13'd0, FETCH_WAIT});

    Op = 2'b00; Funct = 6'b101000; Rd = 4'd15;
    reset_n = 1'b1;
    #1;
    chk("r15.fetch", {13'd0, sig}, {13'd0, FETCH_RDY});
    @(posedge clk);
    #1;
    step("r15.decode", DECODE_S);
    step("r15.execi", EXECI_ADD);
    step("r15.aluwb", ALUWB_PCS);
    chk("r15.retired", Retired, 32'd1);
    chk("r15.retired0", Retired_0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
